// File: rtl/reproductor_secuencia.sv
// +----------------------------------------------------------------------------+
// | reproductor_secuencia                                                      |
// | Challenge-mode playback sequencer: latches a note sequence and drives the  |
// | tone generator one note at a time with timed notes and gaps.               |
// | Optional: SECUENCIA_BUCLE_EN loops playback until detener/reset.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reproductor_secuencia #(
  parameter int NUM_NOTAS    = 10,
  parameter int ANCHO_NOTA   = 3,
  parameter int CICLOS_NOTA  = 25000000,
  parameter int CICLOS_PAUSA = 5000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cargar,
  input  logic [NUM_NOTAS*ANCHO_NOTA-1:0] busNotas,
  input  logic                            tocar,
  input  logic                            detener,
  output logic [ANCHO_NOTA-1:0]           nota_tono,
  output logic                            tono_activo,
  output logic [3:0]                      indice,
  output logic                            ocupado,
  output logic                            fin_reproduccion
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    NOTA   = 2'd1,
    PAUSA  = 2'd2,
    FIN    = 2'd3
  } estado_t;

  localparam int          C_ANCHO_SEC  = NUM_NOTAS * ANCHO_NOTA;
  localparam logic [24:0] C_ULT_NOTA   = 25'(CICLOS_NOTA - 1);
  localparam logic [24:0] C_ULT_PAUSA  = (CICLOS_PAUSA > 0) ? 25'(CICLOS_PAUSA - 1) : 25'd0;
  localparam logic [3:0]  C_ULT_INDICE = 4'(NUM_NOTAS - 1);

  estado_t                  estado_q, estado_d;
  logic [3:0]               indice_q, indice_d;
  logic [24:0]              cnt_q, cnt_d;
  logic [C_ANCHO_SEC-1:0]   seq_q, seq_d;
  logic [ANCHO_NOTA-1:0]    nota_q, nota_d;
  logic                     tono_q, tono_d;
  logic                     ocupado_q, ocupado_d;
  logic                     fin_q, fin_d;
  logic                     fin_hueco;

  always_comb begin
    estado_d  = estado_q;
    indice_d  = indice_q;
    cnt_d     = cnt_q + 25'd1;
    seq_d     = seq_q;
    fin_d     = 1'b0;
    fin_hueco = 1'b0;

    case (estado_q)
      REPOSO: begin
        cnt_d    = 25'd0;
        indice_d = 4'd0;
        if (cargar) seq_d = busNotas;
        if (tocar) estado_d = NOTA;
      end
      NOTA: begin
        if (cnt_q == C_ULT_NOTA) begin
          cnt_d = 25'd0;
          if (CICLOS_PAUSA == 0) fin_hueco = 1'b1;
          else                   estado_d  = PAUSA;
        end
      end
      PAUSA: begin
        if (cnt_q == C_ULT_PAUSA) begin
          cnt_d     = 25'd0;
          fin_hueco = 1'b1;
        end
      end
      default: begin
        estado_d = REPOSO;
        indice_d = 4'd0;
        cnt_d    = 25'd0;
      end
    endcase

    // End of a note slot (note plus its gap): advance, loop or finish.
    if (fin_hueco) begin
      if (indice_q != C_ULT_INDICE) begin
        indice_d = indice_q + 4'd1;
        estado_d = NOTA;
      end else begin
`ifdef SECUENCIA_BUCLE_EN
        indice_d = 4'd0;
        estado_d = NOTA;
`else
        estado_d = FIN;
`endif
        fin_d = 1'b1;
      end
    end

    if (detener) begin
      estado_d = REPOSO;
      indice_d = 4'd0;
      cnt_d    = 25'd0;
      fin_d    = 1'b0;
    end

    // Outputs are registered, so they are derived from the next state.
    nota_d    = '0;
    if (estado_d == NOTA) nota_d = seq_d[int'(indice_d) * ANCHO_NOTA +: ANCHO_NOTA];
    tono_d    = |nota_d;
    ocupado_d = (estado_d != REPOSO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      indice_q  <= 4'd0;
      cnt_q     <= 25'd0;
      seq_q     <= '0;
      nota_q    <= '0;
      tono_q    <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      indice_q  <= indice_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      nota_q    <= nota_d;
      tono_q    <= tono_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign nota_tono        = nota_q;
  assign tono_activo      = tono_q;
  assign indice           = indice_q;
  assign ocupado          = ocupado_q;
  assign fin_reproduccion = fin_q;

endmodule

`default_nettype wire
